// File: rtl/mem_stream_reader_if.sv
// Avalon-MM read-master and Avalon-ST source signals of mem_stream_reader.
// The master modport is the reader's side; the slave modport is the RAM/consumer side.
interface mem_stream_reader_if #(
   parameter int ADDR_W = 12
) ();
   logic [ADDR_W-1:0] m_address;
   logic              m_chipselect;
   logic              m_read;
   logic [3:0]        m_byteenable;
   logic [31:0]       m_readdata;
   logic [31:0]       st_data;
   logic              st_valid;
   logic              st_ready;
   logic              st_sop;
   logic              st_eop;

   modport master (
      output m_address, m_chipselect, m_read, m_byteenable,
      input  m_readdata,
      output st_data, st_valid, st_sop, st_eop,
      input  st_ready
   );

   modport slave (
      input  m_address, m_chipselect, m_read, m_byteenable,
      output m_readdata,
      input  st_data, st_valid, st_sop, st_eop,
      output st_ready
   );
endinterface

// File: rtl/mem_stream_reader.sv
// Streams a block of words from a fixed-latency, no-waitrequest RAM into an Avalon-ST
// source. Reads are credited against a skid FIFO so returning data always has a slot.
module mem_stream_reader #(
   parameter int ADDR_W       = 12,
   parameter int MEM_WORDS    = 3072,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int LEN_W        = 13
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   mem_stream_reader_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_WORDS - 1);
   localparam logic [ADDR_W-1:0] ADDR_SPAN = ADDR_W'(MEM_WORDS);

   logic [1:0]          state;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    remaining;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    pop_cnt;
   logic                zero_done;
   logic [READ_LATENCY:1] vld_pipe;
   logic [31:0]         fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [PW:0]         occ;
   logic [CW-1:0]       inflight;
   logic [CW-1:0]       committed;
   logic                issue, push, pop, credit_ok, drained, kill;

   always_comb begin
      inflight = '0;
      for (int k = 1; k <= READ_LATENCY; k++)
         inflight = inflight + CW'(vld_pipe[k]);
   end

   // A word leaving the FIFO this cycle frees its slot for a read issued this cycle;
   // without that, READ_LATENCY = FIFO_DEPTH-1 could not sustain one word per cycle.
   assign pop       = bus.st_valid && bus.st_ready;
   assign committed = CW'(occ) + inflight - CW'(pop);
   assign credit_ok = committed < CW'(FIFO_DEPTH);
   assign kill      = abort && ((state == ST_ISSUE) || (state == ST_DRAIN));
   assign issue     = (state == ST_ISSUE) && (remaining != '0) && credit_ok && !abort;
   assign push      = vld_pipe[READ_LATENCY];
   assign drained   = (inflight == '0) &&
                      ((occ == '0) || ((occ == (PW+1)'(1)) && pop));

   assign bus.m_read       = issue;
   assign bus.m_chipselect = issue;
   assign bus.m_address    = issue ? addr_q : '0;
   assign bus.m_byteenable = 4'hF;

   assign bus.st_valid = (occ != '0);
   assign bus.st_data  = fifo_mem[rd_ptr];
   assign bus.st_sop   = bus.st_valid && (pop_cnt == '0);
   assign bus.st_eop   = bus.st_valid && (pop_cnt == len_q - LEN_W'(1));

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE) || zero_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         remaining <= '0;
         len_q     <= '0;
         zero_done <= 1'b0;
      end else begin
         zero_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     zero_done <= 1'b1;
                  end else begin
                     state     <= ST_ISSUE;
                     addr_q    <= (base_addr >= ADDR_SPAN) ? base_addr - ADDR_SPAN : base_addr;
                     remaining <= length;
                     len_q     <= length;
                  end
               end
            end
            ST_ISSUE: begin
               if (abort) begin
                  state <= ST_DONE;
               end else if (issue) begin
                  remaining <= remaining - LEN_W'(1);
                  addr_q    <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
                  if (remaining == LEN_W'(1))
                     state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (abort || drained)
                  state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         pop_cnt <= '0;
      else if ((state == ST_IDLE) && start)
         pop_cnt <= '0;
      else if (pop)
         pop_cnt <= pop_cnt + LEN_W'(1);
   end

   // vld_pipe[k] marks a read issued k cycles ago; stage READ_LATENCY lines up with readdata.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
      end else if (kill) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= issue;
         for (int k = 2; k <= READ_LATENCY; k++)
            vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            fifo_mem[i] <= '0;
      end else if (kill) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= bus.m_readdata;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
endmodule
